// File: rtl/or_gate_pkg.sv
// Shared defaults and the saturating-increment helper for the or_gate slice.
// Pure definitions: no latency, no backpressure.
package or_gate_pkg;

  localparam int OR_GATE_WIDTH_DEF = 1;
  localparam int OR_GATE_CNT_W_DEF = 16;

  // Widest counter the helper can serve; narrower counters are zero-extended in.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Updates one cycle after inc/clr; no backpressure, inputs level-sampled.
module sat_counter
  import or_gate_pkg::*;
#(
  parameter int CNT_W = OR_GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  if (CNT_W < 2 || CNT_W > SAT_W) begin : g_bad_cnt_w
    $error("sat_counter: CNT_W out of range");
  end

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic [SAT_W-1:0] cnt_inc;

  assign cnt_inc = sat_inc(SAT_W'(cnt), CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/or_gate.sv
// Bitwise OR with combinational and registered results plus an activity counter.
// c/c_any zero latency, c_q/hi_count one cycle; no handshake, inputs sampled every cycle.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_GATE_WIDTH_DEF,
  parameter int CNT_W = OR_GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             c_any,
  input  logic             clr_count,
  output logic [CNT_W-1:0] hi_count
);

  if (WIDTH < 1) begin : g_bad_width
    $error("or_gate: WIDTH must be at least 1");
  end

  // Kept free of any clock so the result is valid even while held in reset.
  assign c     = a | b;
  assign c_any = |c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else begin
      c_q <= a | b;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hi_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_count),
    .inc   (c_any),
    .cnt   (hi_count)
  );

endmodule

// File: tb/tb_or_gate.sv
// Scoreboard bench for or_gate: a 1-bit/16-bit-counter instance and a 4-bit/2-bit-counter instance.
module tb_or_gate;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        clr_count;
  logic        a1, b1, c1, cq1, any1;
  logic [15:0] hi1;
  logic [3:0]  a4, b4, c4, cq4;
  logic        any4;
  logic [1:0]  hi4;

  or_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .c_q(cq1),
    .c_any(any1), .clr_count(clr_count), .hi_count(hi1)
  );

  or_gate #(.WIDTH(4), .CNT_W(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .c_q(cq4),
    .c_any(any4), .clr_count(clr_count), .hi_count(hi4)
  );

  typedef struct {
    logic       c1;
    logic       any1;
    logic [3:0] c4;
    logic       any4;
    logic       cq1;
    logic [3:0] cq4;
    int         hi1;
    int         hi4;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_hi1 = 0;
  int   m_hi4 = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each bit is 1 unless both operands are 0; counter counts active
  // cycles, zeroed by clear, capped at its all-ones value.
  function automatic logic [3:0] ref_or(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = !(x[i] == 1'b0 && y[i] == 1'b0);
    return r;
  endfunction

  function automatic int ref_count(input int cur, input bit clr, input bit act, input int max_v);
    if (clr) return 0;
    if (act && cur < max_v) return cur + 1;
    return cur;
  endfunction

  // Called at a falling edge: drives inputs, predicts the next rising edge, waits a cycle.
  task automatic step(input logic na1, input logic nb1, input logic [3:0] na4,
                      input logic [3:0] nb4, input logic nclr);
    exp_t e;
    a1 = na1; b1 = nb1; a4 = na4; b4 = nb4; clr_count = nclr;
    e.c1   = ref_or({3'b0, na1}, {3'b0, nb1}) != 4'd0;
    e.any1 = e.c1;
    e.c4   = ref_or(na4, nb4);
    e.any4 = (na4 != 4'd0) || (nb4 != 4'd0);
    e.cq1  = e.c1;
    e.cq4  = e.c4;
    m_hi1  = ref_count(m_hi1, nclr, e.any1, 65535);
    m_hi4  = ref_count(m_hi4, nclr, e.any4, 3);
    e.hi1  = m_hi1;
    e.hi4  = m_hi4;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("c1",   32'(c1),   32'(e.c1));
        check("any1", 32'(any1), 32'(e.any1));
        check("c4",   32'(c4),   32'(e.c4));
        check("any4", 32'(any4), 32'(e.any4));
        check("cq1",  32'(cq1),  32'(e.cq1));
        check("cq4",  32'(cq4),  32'(e.cq4));
        check("hi1",  32'(hi1),  32'(e.hi1));
        check("hi4",  32'(hi4),  32'(e.hi4));
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] ra, rb;
    clk_en = 1'b0; rst_n = 1'b0; clr_count = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;

    // No clock, held in reset: combinational path alone.
    for (int i = 0; i < 4; i++) begin
      v = 4'(i);
      a1 = v[1]; b1 = v[0];
      a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      #10;
      check("rst_c1",   32'(c1),   32'(v[1] | v[0]));
      check("rst_any1", 32'(any1), 32'(v[1] | v[0]));
      check("rst_c4",   32'(c4),   32'(ref_or(a4, b4)));
      check("rst_cq1",  32'(cq1),  32'd0);
      check("rst_hi1",  32'(hi1),  32'd0);
      check("rst_hi4",  32'(hi4),  32'd0);
    end

    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 4'b1010, 4'b0101, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 2) == 0) ra = 4'd0;
      step(ra[0], rb[0], ra, rb, ($urandom_range(0, 15) == 0));
    end

    // Saturate the narrow counter, then reset between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b0110, 4'b0000, 1'b0);
    drain();
    check("pre_hi4", 32'(hi4), 32'd3);
    check("pre_cq4", 32'(cq4), 32'h6);
    a4 = 4'b1001; b4 = 4'b0100;
    rst_n = 1'b0;
    #1;
    check("arst_cq4", 32'(cq4), 32'd0);
    check("arst_hi4", 32'(hi4), 32'd0);
    check("arst_cq1", 32'(cq1), 32'd0);
    check("arst_hi1", 32'(hi1), 32'd0);
    check("arst_c4",  32'(c4),  32'hd);
    @(posedge clk);
    #1;
    check("arst_hold_hi4", 32'(hi4), 32'd0);
    check("arst_hold_cq4", 32'(cq4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi1 = 0; m_hi4 = 0;

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(ra[1], rb[2], ra, rb, ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
